// File: rtl/resultado_bcd_display.sv
// Binary-to-BCD conversion of the Resultado word (sequential double-dabble)
// and a multiplexed, active-low 7-segment display driver for the BCD digits.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a rising edge on done_in; bcd_out holds last value
// S_SHIFT | one add-3/shift-left step per cycle, W steps in total
// S_LOAD  | copy BCD field to bcd_out, pulse bcd_valid, drop busy
module resultado_bcd_display #(
    parameter int W        = 16,
    parameter int DIGITS   = 5,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 1
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  done_in,
    input  logic [W-1:0]          resultado,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int SR_W   = 4*DIGITS + W;
    localparam int CNT_W  = (W > 1) ? $clog2(W) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_ZERO = 7'h40;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SR_W-1:0]       sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  done_d_q;
    logic                  trigger;
    logic [SR_W-1:0]       adj;

    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;

    // Active-low segment pattern {g,f,e,d,c,b,a} for digit k of v, with
    // leading-zero blanking: digit k>0 goes dark when it and every higher
    // digit are zero. Non-decimal nibbles show nothing.
    function automatic logic [6:0] seg_of(input logic [4*DIGITS-1:0] v,
                                          input logic [IDX_W-1:0]    k);
        logic [3:0] nib;
        logic       nz;
        logic [6:0] s;
        nib = v[4*int'(k) +: 4];
        nz  = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(k)) nz = nz | (|v[4*j +: 4]);
        end
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_OFF;
        endcase
        if (BLANK != 0 && k != '0 && !nz) s = SEG_OFF;
        return s;
    endfunction

    // Rising edge on done_in starts a conversion only when idle; edges seen
    // while busy are dropped rather than queued.
    assign trigger = done_in & ~done_d_q & (state_q == S_IDLE);

    // Conversion state register and edge-detect history.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            bcd_q    <= '0;
            done_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            bcd_q    <= bcd_d;
            done_d_q <= done_in;
        end
    end

    // Double-dabble next state: correct nibbles >=5 by +3, then shift left.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        adj     = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[W+4*i +: 4] >= 4'd5) begin
                adj[W+4*i +: 4] = sr_q[W+4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    sr_d    = {{(4*DIGITS){1'b0}}, resultado};
                    cnt_d   = CNT_W'(W-1);
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d = adj << 1;
                if (cnt_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOAD: begin
                bcd_d   = sr_q[SR_W-1:W];
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Display scan registers; seg and an are registered together so they
    // always refer to the same digit slot.
    always_ff @(posedge ck) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_ZERO;
            an_q   <= ~DIGITS'(1);
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    // Free-running slot counter; digit index advances at each wrap. The
    // segment decode uses next-cycle bcd/index so a new result appears with
    // no extra register lag.
    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV-1)) begin
            scan_d = '0;
            if (idx_q == IDX_W'(DIGITS-1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            scan_d = scan_q + SCAN_W'(1);
        end
        an_d  = ~(DIGITS'(1) << idx_d);
        seg_d = seg_of(bcd_d, idx_d);
    end

    assign busy      = busy_q;
    assign bcd_valid = valid_q;
    assign bcd_out   = bcd_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_resultado_bcd_display.sv
// Bench for resultado_bcd_display: decimal reference model, directed and
// random conversions, display scan and blanking, dropped edges, reset abort.
module tb_resultado_bcd_display;

    localparam int W        = 16;
    localparam int DIGITS   = 5;
    localparam int SCAN_DIV = 4;

    logic                ck;
    logic                rst;
    logic                done_in;
    logic [W-1:0]        resultado;
    logic                busy;
    logic                bcd_valid;
    logic [4*DIGITS-1:0] bcd_out;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    int passed = 0;
    int total  = 0;

    resultado_bcd_display #(
        .W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(1)
    ) dut (
        .ck(ck), .rst(rst), .done_in(done_in), .resultado(resultado),
        .busy(busy), .bcd_valid(bcd_valid), .bcd_out(bcd_out),
        .seg(seg), .an(an)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference: decimal digits by division.
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Reference: active-low segments for digit i of v, leading zeros blank.
    function automatic logic [6:0] ref_seg(input int v, input int i);
        logic [6:0] tab [10];
        int p;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (i > 0 && v < p) return 7'h7F;
        return tab[(v / p) % 10];
    endfunction

    // Drive a fresh rising edge with value v and observe 40 cycles after
    // the trigger edge T (k = edges after T).
    task automatic do_conv(input int v, output int lat, output int pulses,
                           output int busy_cnt, output logic [19:0] res,
                           output logic [19:0] pre16);
        done_in = 1'b0;
        @(negedge ck);
        resultado = W'(v);
        done_in   = 1'b1;
        lat = -1; pulses = 0; busy_cnt = 0; res = 'x; pre16 = 'x;
        for (int k = 0; k < 40; k++) begin
            @(negedge ck);
            if (busy === 1'b1) busy_cnt++;
            if (k == 16) pre16 = bcd_out;
            if (bcd_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = bcd_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        int vcount;
        int bcount;
        rst = 1'b1; done_in = 1'b1; resultado = 16'd1234;
        repeat (3) @(posedge ck);
        @(negedge ck);
        rst = 1'b0;
        total++; if (bcd_out !== 20'h0) $display("FAIL reset_bcd got=%h exp=00000", bcd_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (an !== 5'b11110) $display("FAIL reset_an got=%b exp=11110", an); else passed++;
        total++; if (seg !== 7'h40) $display("FAIL reset_seg got=%h exp=40", seg); else passed++;
        vcount = 0; bcount = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge ck);
            if (bcd_valid !== 1'b0) vcount++;
            if (busy !== 1'b0) bcount++;
        end
        total++; if (vcount != 0) $display("FAIL reset_no_valid got=%0d exp=0", vcount); else passed++;
        total++; if (bcount != 0) $display("FAIL reset_no_busy got=%0d exp=0", bcount); else passed++;
    endtask

    task automatic test_conv(input int v, input logic [19:0] prev);
        int lat, pulses, bc;
        logic [19:0] res, pre16;
        do_conv(v, lat, pulses, bc, res, pre16);
        total++; if (res !== ref_bcd(v)) $display("FAIL conv_value v=%0d got=%h exp=%h", v, res, ref_bcd(v)); else passed++;
        total++; if (lat != W+1) $display("FAIL conv_latency v=%0d got=%0d exp=%0d", v, lat, W+1); else passed++;
        total++; if (pulses != 1) $display("FAIL conv_pulses v=%0d got=%0d exp=1", v, pulses); else passed++;
        total++; if (bc != W+1) $display("FAIL conv_busy_cycles v=%0d got=%0d exp=%0d", v, bc, W+1); else passed++;
        total++; if (pre16 !== prev) $display("FAIL conv_held v=%0d got=%h exp=%h", v, pre16, prev); else passed++;
        total++; if (bcd_out !== ref_bcd(v)) $display("FAIL conv_hold_after v=%0d got=%h exp=%h", v, bcd_out, ref_bcd(v)); else passed++;
    endtask

    task automatic test_display(input int v);
        int cnt [DIGITS];
        int idx;
        for (int i = 0; i < DIGITS; i++) cnt[i] = 0;
        for (int k = 0; k < SCAN_DIV*DIGITS; k++) begin
            @(negedge ck);
            idx = -1;
            for (int i = 0; i < DIGITS; i++) if (an === ~(5'b00001 << i)) idx = i;
            total++;
            if (idx < 0) begin
                $display("FAIL disp_an v=%0d got=%b exp=one-hot-low", v, an);
            end else begin
                passed++;
                cnt[idx]++;
                total++;
                if (seg !== ref_seg(v, idx))
                    $display("FAIL disp_seg v=%0d digit=%0d got=%h exp=%h", v, idx, seg, ref_seg(v, idx));
                else passed++;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            total++;
            if (cnt[i] != SCAN_DIV) $display("FAIL disp_slot v=%0d digit=%0d got=%0d exp=%0d", v, i, cnt[i], SCAN_DIV);
            else passed++;
        end
    endtask

    task automatic test_busy_drop();
        int pulses;
        logic [19:0] res;
        done_in = 1'b0;
        @(negedge ck);
        resultado = 16'd500; done_in = 1'b1;
        pulses = 0; res = 'x;
        for (int k = 0; k < 50; k++) begin
            @(negedge ck);
            if (k == 3) done_in = 1'b0;
            if (k == 4) begin resultado = 16'd999; done_in = 1'b1; end
            if (bcd_valid === 1'b1) begin pulses++; res = bcd_out; end
        end
        total++; if (res !== 20'h00500) $display("FAIL drop_value got=%h exp=00500", res); else passed++;
        total++; if (pulses != 1) $display("FAIL drop_pulses got=%0d exp=1", pulses); else passed++;
        total++; if (bcd_out !== 20'h00500) $display("FAIL drop_hold got=%h exp=00500", bcd_out); else passed++;
    endtask

    task automatic test_reset_mid();
        int pulses, bc;
        done_in = 1'b0;
        @(negedge ck);
        resultado = 16'd4321; done_in = 1'b1;
        pulses = 0; bc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge ck);
            if (bcd_valid === 1'b1) pulses++;
        end
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
        total++; if (bcd_out !== 20'h0) $display("FAIL midrst_bcd got=%h exp=00000", bcd_out); else passed++;
        for (int k = 0; k < 30; k++) begin
            @(negedge ck);
            if (bcd_valid === 1'b1) pulses++;
            if (busy === 1'b1) bc++;
        end
        total++; if (pulses != 0) $display("FAIL midrst_no_valid got=%0d exp=0", pulses); else passed++;
        total++; if (bc != 0) $display("FAIL midrst_no_retrigger got=%0d exp=0", bc); else passed++;
        test_conv(7, 20'h0);
    endtask

    task automatic test_random();
        int v;
        logic [19:0] prev;
        prev = bcd_out;
        for (int n = 0; n < 12; n++) begin
            v = int'($urandom_range(0, 65535));
            test_conv(v, prev);
            prev = ref_bcd(v);
            if (n < 3) test_display(v);
        end
    endtask

    initial begin
        rst = 1'b1; done_in = 1'b1; resultado = '0;
        test_reset();
        test_conv(65535, 20'h0);
        test_conv(1234, 20'h65535);
        test_display(1234);
        test_conv(0, 20'h01234);
        test_display(0);
        test_busy_drop();
        test_reset_mid();
        test_display(7);
        test_random();
        test_conv(9, bcd_out);
        test_display(9);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
